// File: rtl/pool2x2_stream.sv
// pool2x2_stream: streaming 2x2 stride-2 pooling of a raster-order pixel stream.
// One half-width line buffer holds the pair results of each even row; the
// following odd row combines them with its own pairs and emits one pixel per tile.
// Trailing odd column / odd row are consumed and discarded.
// Optional feature macro: POOL2X2_AVG_EN (defined = average pooling, else max pooling).
module pool2x2_stream #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned IN_COLS   = 538,
  parameter int unsigned IN_ROWS   = 538
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_pixel,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out_pixel,
  output logic                 out_row_end,
  output logic                 out_frame_end
);

  localparam int unsigned OUT_COLS = IN_COLS / 2;
  localparam int unsigned OUT_ROWS = IN_ROWS / 2;
  localparam int unsigned COL_W    = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
  localparam int unsigned ROW_W    = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
  localparam int unsigned ADDR_W   = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
`ifdef POOL2X2_AVG_EN
  localparam int unsigned LB_W     = WORD_SIZE + 1;
  localparam int unsigned SUM_W    = WORD_SIZE + 2;
`else
  localparam int unsigned LB_W     = WORD_SIZE;
`endif
  localparam bit COLS_ODD = (IN_COLS % 2) == 1;
  localparam bit ROWS_ODD = (IN_ROWS % 2) == 1;

  typedef enum logic [1:0] {FILL, EMIT, DROP} state_t;

  state_t               state;
  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic [WORD_SIZE-1:0] hreg;
  logic [LB_W-1:0]      linebuf [OUT_COLS];

  logic [ADDR_W-1:0]    addr_c;
  logic                 last_col_c;
  logic                 last_row_c;
  logic                 tile_row_end_c;
  logic                 tile_frame_end_c;
  logic [LB_W-1:0]      lb_rd_c;
  logic [LB_W-1:0]      pair_c;
  logic [WORD_SIZE-1:0] pool_c;
`ifdef POOL2X2_AVG_EN
  logic [SUM_W-1:0]     sum_c;
`endif

  // Position decode and the pair / tile reduction for the current beat
  always_comb begin
    addr_c           = ADDR_W'(col >> 1);
    last_col_c       = (col == COL_W'(IN_COLS - 1));
    last_row_c       = (row == ROW_W'(IN_ROWS - 1));
    tile_row_end_c   = (addr_c == ADDR_W'(OUT_COLS - 1));
    tile_frame_end_c = tile_row_end_c && (ROW_W'(row >> 1) == ROW_W'(OUT_ROWS - 1));
    lb_rd_c          = linebuf[addr_c];
`ifdef POOL2X2_AVG_EN
    pair_c = LB_W'(hreg) + LB_W'(in_pixel);
    sum_c  = SUM_W'(lb_rd_c) + SUM_W'(pair_c);
    pool_c = WORD_SIZE'(sum_c >> 2);
`else
    pair_c = (in_pixel > hreg) ? in_pixel : hreg;
    pool_c = (lb_rd_c > pair_c) ? lb_rd_c : pair_c;
`endif
  end

  // Line buffer: pair results of the even row, indexed by output column
  always_ff @(posedge clk) begin
    if (in_valid && col[0] && (state == FILL)) begin
      linebuf[addr_c] <= pair_c;
    end
  end

  // Counters, row-phase FSM, horizontal register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FILL;
      col           <= '0;
      row           <= '0;
      hreg          <= '0;
      out_valid     <= 1'b0;
      out_pixel     <= '0;
      out_row_end   <= 1'b0;
      out_frame_end <= 1'b0;
    end else begin
      out_valid     <= 1'b0;
      out_row_end   <= 1'b0;
      out_frame_end <= 1'b0;
      if (in_valid) begin
        if (!col[0]) begin
          // the unpaired last pixel of an odd-width row is dropped
          if (!(COLS_ODD && last_col_c)) begin
            hreg <= in_pixel;
          end
        end else if (state == EMIT) begin
          out_valid     <= 1'b1;
          out_pixel     <= pool_c;
          out_row_end   <= tile_row_end_c;
          out_frame_end <= tile_frame_end_c;
        end

        if (last_col_c) begin
          col <= '0;
          row <= last_row_c ? '0 : row + ROW_W'(1);
          case (state)
            FILL:    state <= EMIT;
            EMIT: begin
              if (last_row_c) begin
                state <= FILL;
              end else if (ROWS_ODD && (row == ROW_W'(IN_ROWS - 2))) begin
                state <= DROP;
              end else begin
                state <= FILL;
              end
            end
            DROP:    state <= FILL;
            default: state <= FILL;
          endcase
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Testbench for pool2x2_stream: a 4x4 and a 5x5 instance share the stimulus;
// expected tiles come from a stored copy of the frame.
module tb_pool2x2_stream;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         iv4, iv5;
  logic [W-1:0] ipix;
  logic         ov4, re4, fe4, ov5, re5, fe5;
  logic [W-1:0] op4, op5;

  always #5 clk = ~clk;

  pool2x2_stream #(.WORD_SIZE(W), .IN_COLS(4), .IN_ROWS(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_pixel(ipix),
    .out_valid(ov4), .out_pixel(op4), .out_row_end(re4), .out_frame_end(fe4));

  pool2x2_stream #(.WORD_SIZE(W), .IN_COLS(5), .IN_ROWS(5)) u5 (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_pixel(ipix),
    .out_valid(ov5), .out_pixel(op5), .out_row_end(re5), .out_frame_end(fe5));

  int           sel;
  int           ncols, nrows, br, bc;
  int           n_cmp, n_bad;
  logic [W-1:0] pix [0:4][0:4];
  logic         exp_v, exp_re, exp_fe;
  logic [W-1:0] exp_p;
  logic [W-1:0] got [$];

  logic         ov, re, fe;
  logic [W-1:0] op;
  assign ov = (sel == 1) ? ov5 : ov4;
  assign re = (sel == 1) ? re5 : re4;
  assign fe = (sel == 1) ? fe5 : fe4;
  assign op = (sel == 1) ? op5 : op4;

  function automatic logic [W-1:0] pool4(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c, input logic [W-1:0] d);
`ifdef POOL2X2_AVG_EN
    int s;
    s = int'(a) + int'(b) + int'(c) + int'(d);
    return W'(s / 4);
`else
    logic [W-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
`endif
  endfunction

  // Drive one cycle on the selected instance and predict its response
  task automatic put(input bit v, input logic [W-1:0] p);
    @(negedge clk);
    iv4    = v && (sel == 0);
    iv5    = v && (sel == 1);
    ipix   = p;
    exp_v  = 1'b0;
    exp_re = 1'b0;
    exp_fe = 1'b0;
    if (v) begin
      pix[br][bc] = p;
      if ((br % 2 == 1) && (bc % 2 == 1) && (bc / 2 < ncols / 2) && (br / 2 < nrows / 2)) begin
        exp_v  = 1'b1;
        exp_p  = pool4(pix[br-1][bc-1], pix[br-1][bc], pix[br][bc-1], p);
        exp_re = (bc / 2 == ncols / 2 - 1);
        exp_fe = exp_re && (br / 2 == nrows / 2 - 1);
      end
      bc++;
      if (bc == ncols) begin
        bc = 0;
        br++;
        if (br == nrows) br = 0;
      end
    end
  endtask

  task automatic do_reset(input int s, input int nc, input int nr);
    @(negedge clk);
    rst = 1'b1; iv4 = 1'b0; iv5 = 1'b0; ipix = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sel = s; ncols = nc; nrows = nr; br = 0; bc = 0;
    exp_v = 1'b0; exp_re = 1'b0; exp_fe = 1'b0; exp_p = '0;
    got.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; iv4 = 1'b0; iv5 = 1'b0; ipix = '0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ov4, re4, fe4, op4} !== {3'b000, W'(0)}) begin
      n_bad++; $display("FAIL reset_4x4: v/re/fe/pix = %b/%b/%b/%0d, required 0/0/0/0", ov4, re4, fe4, op4);
    end
    n_cmp++;
    if ({ov5, re5, fe5, op5} !== {3'b000, W'(0)}) begin
      n_bad++; $display("FAIL reset_5x5: v/re/fe/pix = %b/%b/%b/%0d, required 0/0/0/0", ov5, re5, fe5, op5);
    end
  endtask

  task automatic test_ramp4(input bit gapped);
    logic [W-1:0] want [4];
`ifdef POOL2X2_AVG_EN
    want = '{8'd2, 8'd4, 8'd10, 8'd12};
`else
    want = '{8'd5, 8'd7, 8'd13, 8'd15};
`endif
    do_reset(0, 4, 4);
    for (int i = 0; i < 32; i++) begin
      if (!gapped && (i % 2 == 1)) continue;
      if (i % 2 == 0) put(1'b1, W'(i / 2)); else put(1'b0, W'($urandom));
      @(posedge clk); #1;
      n_cmp++;
      if (ov !== exp_v || re !== exp_re || fe !== exp_fe || op !== exp_p) begin
        n_bad++;
        $display("FAIL ramp4 gapped=%0d step %0d: v/re/fe/pix = %b/%b/%b/%0d, required %b/%b/%b/%0d",
                 gapped, i, ov, re, fe, op, exp_v, exp_re, exp_fe, exp_p);
      end
      if (ov === 1'b1) got.push_back(op);
    end
    n_cmp++;
    if (got.size() != 4) begin
      n_bad++; $display("FAIL ramp4_count gapped=%0d: %0d outputs, required 4", gapped, got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (got[k] !== want[k]) begin
          n_bad++; $display("FAIL ramp4_value gapped=%0d #%0d: %0d, required %0d", gapped, k, got[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_odd_dims();
    logic [W-1:0] want [5];
`ifdef POOL2X2_AVG_EN
    want = '{8'd3, 8'd5, 8'd13, 8'd15, 8'd3};
`else
    want = '{8'd6, 8'd8, 8'd16, 8'd18, 8'd6};
`endif
    do_reset(1, 5, 5);
    for (int i = 0; i < 50; i++) begin
      put(1'b1, W'(i % 25));
      @(posedge clk); #1;
      n_cmp++;
      if (ov !== exp_v || re !== exp_re || fe !== exp_fe || op !== exp_p) begin
        n_bad++;
        $display("FAIL odd5 beat %0d: v/re/fe/pix = %b/%b/%b/%0d, required %b/%b/%b/%0d",
                 i, ov, re, fe, op, exp_v, exp_re, exp_fe, exp_p);
      end
      if (ov === 1'b1) got.push_back(op);
    end
    n_cmp++;
    if (got.size() != 8) begin
      n_bad++; $display("FAIL odd5_count: %0d outputs, required 8", got.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (got[k] !== want[k]) begin
          n_bad++; $display("FAIL odd5_value #%0d: %0d, required %0d", k, got[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset(0, 4, 4);
    for (int i = 0; i < 6; i++) begin
      put(1'b1, W'(100 + i));
      @(posedge clk); #1;
      n_cmp++;
      if (ov !== exp_v || re !== exp_re || fe !== exp_fe || op !== exp_p) begin
        n_bad++;
        $display("FAIL midreset_pre beat %0d: v/re/fe/pix = %b/%b/%b/%0d, required %b/%b/%b/%0d",
                 i, ov, re, fe, op, exp_v, exp_re, exp_fe, exp_p);
      end
    end
    @(negedge clk);
    rst = 1'b1; iv4 = 1'b1; ipix = 8'd200;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({ov, re, fe, op} !== {3'b000, W'(0)}) begin
        n_bad++; $display("FAIL midreset_hold cycle %0d: v/re/fe/pix = %b/%b/%b/%0d, required 0/0/0/0", i, ov, re, fe, op);
      end
    end
    @(negedge clk);
    rst = 1'b0; iv4 = 1'b0;
    br = 0; bc = 0; exp_p = '0;
    for (int i = 0; i < 16; i++) begin
      put(1'b1, W'(i));
      @(posedge clk); #1;
      n_cmp++;
      if (ov !== exp_v || re !== exp_re || fe !== exp_fe || op !== exp_p) begin
        n_bad++;
        $display("FAIL midreset_post beat %0d: v/re/fe/pix = %b/%b/%b/%0d, required %b/%b/%b/%0d",
                 i, ov, re, fe, op, exp_v, exp_re, exp_fe, exp_p);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nout, nfe;
    nout = 0; nfe = 0;
    do_reset(0, 4, 4);
    for (int i = 0; i < 48; i++) begin
      put(1'b1, 8'd255);
      @(posedge clk); #1;
      n_cmp++;
      if (ov !== exp_v || re !== exp_re || fe !== exp_fe || op !== exp_p) begin
        n_bad++;
        $display("FAIL b2b beat %0d: v/re/fe/pix = %b/%b/%b/%0d, required %b/%b/%b/%0d",
                 i, ov, re, fe, op, exp_v, exp_re, exp_fe, exp_p);
      end
      if (ov === 1'b1) begin
        nout++;
        if (fe === 1'b1) nfe++;
      end
    end
    n_cmp++;
    if (nout != 12 || nfe != 3) begin
      n_bad++; $display("FAIL b2b_counts: outputs=%0d frame_ends=%0d, required 12 and 3", nout, nfe);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      do_reset(s, (s == 1) ? 5 : 4, (s == 1) ? 5 : 4);
      for (int i = 0; i < 180; i++) begin
        if ($urandom_range(0, 2) == 0) put(1'b0, W'($urandom));
        else put(1'b1, W'($urandom));
        @(posedge clk); #1;
        n_cmp++;
        if (ov !== exp_v || re !== exp_re || fe !== exp_fe || op !== exp_p) begin
          n_bad++;
          $display("FAIL random cfg=%0d step %0d: v/re/fe/pix = %b/%b/%b/%0d, required %b/%b/%b/%0d",
                   s, i, ov, re, fe, op, exp_v, exp_re, exp_fe, exp_p);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    br = 0; bc = 0; ncols = 4; nrows = 4;
    test_reset();
    test_ramp4(1'b0);
    test_ramp4(1'b1);
    test_odd_dims();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pool2x2_stream.md
# pool2x2_stream

Streaming 2x2 stride-2 max-pooling stage that sits directly downstream of the 3x3 Laplacian convolution stage in the CNN pixel pipeline. It consumes one convolved pixel per strobe in raster order and emits one pooled pixel per 2x2 input tile. It halves each frame dimension using a single half-width line buffer and no backpressure. Its output feeds the next feature-map stage or a capture FIFO.

## Interface
- WORD_SIZE, 8: pixel width, unsigned.
- IN_COLS, 538: valid convolved pixels per row (convolution ROW_SIZE-2).
- IN_ROWS, 538: convolved rows per frame.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_pixel carries a valid convolved pixel this cycle; integration aligns it with the pixel.
- in_pixel  in  WORD_SIZE  convolved pixel, raster order.
- out_valid  out  1  one-cycle strobe: out_pixel holds a pooled result.
- out_pixel  out  WORD_SIZE  pooled pixel.
- out_row_end  out  1  qualifies out_valid: last pooled pixel of an output row.
- out_frame_end  out  1  qualifies out_valid: last pooled pixel of the frame.

## Operation
- Counters advance only on in_valid: col (0..IN_COLS-1), row (0..IN_ROWS-1). col wraps to 0 and increments row. row wraps to 0 after the last pixel of the frame.
- OUT_COLS = IN_COLS/2 and OUT_ROWS = IN_ROWS/2, both floor. Trailing odd column and trailing odd row are consumed and discarded.
- FSM, updated on the last accepted pixel of each row:
  - FILL: even row. Next state is EMIT.
  - EMIT: odd row. Next state is FILL, or DROP if the next row index is IN_ROWS-1 and IN_ROWS is odd, or FILL at frame wrap.
  - DROP: trailing odd row. Pixels are counted only. Next state is FILL at frame wrap.
- Datapath:
  - hreg latches in_pixel at even col.
  - FILL, odd col: linebuf[col>>1] <= max(hreg, in_pixel).
  - EMIT, odd col: out_pixel <= max(linebuf[col>>1], hreg, in_pixel), and out_valid pulses.
  - When col == IN_COLS-1 and IN_COLS is odd, that pixel is ignored.
- linebuf has OUT_COLS entries of WORD_SIZE bits each, synchronous write and combinational or registered read. Every read entry must have been written in the preceding FILL row.
- out_row_end = (col>>1 == OUT_COLS-1) on the emitting beat.
- out_frame_end = out_row_end AND the current EMIT row is output row OUT_ROWS-1.
- Comparisons are unsigned. No saturation is needed because the result is always one of the inputs.

## Timing
- Latency: out_valid asserts exactly 1 cycle after the accepted in_valid beat at (odd row, odd col).
- Throughput: one input per cycle sustained. in_valid gaps of any length are allowed and do not alter results.
- out_valid, out_row_end and out_frame_end are single-cycle pulses. out_pixel holds its value between pulses.
- Reset values: out_valid=0, out_pixel=0, out_row_end=0, out_frame_end=0, col=0, row=0, hreg=0, FSM=FILL. linebuf is not reset.
- Reset mid-frame aborts the partial frame with no output. The first in_valid after reset is treated as pixel (0,0).
- in_valid held high across a frame boundary: pixel (0,0) of the next frame is accepted on the cycle after the last pixel. No bubble.

## Configuration
- POOL2X2_AVG_EN:
  - Defined: average pooling. linebuf stores the pair sum (WORD_SIZE+1 bits). Output is the 4-pixel sum (WORD_SIZE+2 bits) >>2, truncated. Latency and strobes are unchanged.
  - Undefined: max pooling as above.

## Test plan
- Max mode, IN_COLS=4, IN_ROWS=4, ramp p=4r+c (0..15), in_valid continuous:
  - Outputs 5, 7, 13, 15.
  - out_valid 1 cycle after input indices 5, 7, 13, 15.
  - row_end on outputs 2 and 4; frame_end on output 4 only.
- Same ramp with in_valid toggling 1/0 -> identical outputs and flags; each pulse is 1 cycle after its triggering beat.
- IN_COLS=5, IN_ROWS=5, ramp p=5r+c:
  - Outputs 6, 8, 16, 18, frame_end on 18.
  - 25 pixels consumed with no other output.
  - The next frame's first output is 6.
- Reset asserted after 6 pixels of a 4x4 frame -> no output; all outputs 0. A following 16-pixel ramp gives 5, 7, 13, 15.
- Back-to-back frames of all 255 -> every output 255; frame_end every 4th output with no gaps.
- POOL2X2_AVG_EN defined, 4x4 ramp -> outputs 2, 4, 10, 12. A tile of 255, 255, 255, 254 -> 254.
